icetap_capture_ctrl: RTL

ICETAP_CAPTURE_CTRL -- requirements
Module: icetap_capture_ctrl

---
 rtl/icetap_capture_ctrl_if.sv | 27 ++
 rtl/icetap_capture_ctrl.sv | 139 +++++++++++++
 2 files changed

// File: rtl/icetap_capture_ctrl_if.sv
// rtl/icetap_capture_ctrl_if.sv - command strobe and sample RAM write bus of the capture controller
interface icetap_capture_ctrl_if #(
  parameter int NR_SIGNALS    = 1,
  parameter int RAM_ADDR_BITS = 8
);
  logic                     cmd_valid;
  logic [1:0]               cmd;
  logic                     ram_wr_ena;
  logic [RAM_ADDR_BITS-1:0] ram_wr_addr;
  logic [NR_SIGNALS-1:0]    ram_wr_data;

  modport master (
    output cmd_valid,
    output cmd,
    input  ram_wr_ena,
    input  ram_wr_addr,
    input  ram_wr_data
  );

  modport slave (
    input  cmd_valid,
    input  cmd,
    output ram_wr_ena,
    output ram_wr_addr,
    output ram_wr_data
  );
endinterface

// File: rtl/icetap_capture_ctrl.sv
// rtl/icetap_capture_ctrl.sv - logic-analyzer capture FSM driving a circular sample RAM
module icetap_capture_ctrl #(
  parameter int NR_SIGNALS    = 1,
  parameter int RAM_ADDR_BITS = 8
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic [NR_SIGNALS-1:0]    signals,
  input  logic [NR_SIGNALS-1:0]    store_mask,
  input  logic [NR_SIGNALS-1:0]    trigger_mask,
  input  logic [NR_SIGNALS-1:0]    trigger_value,
  input  logic [RAM_ADDR_BITS-1:0] post_trig_cnt,
  icetap_capture_ctrl_if.slave     bus,
  output logic [2:0]               state,
  output logic [RAM_ADDR_BITS-1:0] trigger_addr,
  output logic                     wrapped,
  output logic                     busy
);

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_ARMED     = 3'd1,
    ST_POST_TRIG = 3'd2,
    ST_DONE      = 3'd3
  } state_t;

  localparam logic [1:0] CMD_START = 2'd1;
  localparam logic [1:0] CMD_STOP  = 2'd2;
  localparam logic [1:0] CMD_CLEAR = 2'd3;

  state_t                   state_q;
  state_t                   state_d;
  logic [RAM_ADDR_BITS-1:0] wr_ptr;
  logic [RAM_ADDR_BITS-1:0] remain;
  logic [NR_SIGNALS-1:0]    prev_signals;
  logic                     store_hit;
  logic                     trig_hit;
  logic                     cmd_start;
  logic                     cmd_stop;
  logic                     cmd_clear;
  logic                     cmd_any;
  logic                     capturing;
  logic                     wr_ena;

  assign cmd_start = bus.cmd_valid && (bus.cmd == CMD_START);
  assign cmd_stop  = bus.cmd_valid && (bus.cmd == CMD_STOP);
  assign cmd_clear = bus.cmd_valid && (bus.cmd == CMD_CLEAR);
  // Any real command owns its cycle, so no sample is written alongside it.
  assign cmd_any   = cmd_start || cmd_stop || cmd_clear;

  assign store_hit = (store_mask == '0) || (((signals ^ prev_signals) & store_mask) != '0);
  assign trig_hit  = ((signals ^ trigger_value) & trigger_mask) == '0;
  assign capturing = (state_q == ST_ARMED) || (state_q == ST_POST_TRIG);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (cmd_clear) begin
      state_d = ST_IDLE;
    end else if (cmd_start) begin
      state_d = ST_ARMED;
    end else if (cmd_stop && capturing) begin
      state_d = ST_DONE;
    end else begin
      case (state_q)
        ST_ARMED: begin
          if (trig_hit) begin
            state_d = (post_trig_cnt == '0) ? ST_DONE : ST_POST_TRIG;
          end
        end
        ST_POST_TRIG: begin
          if (store_hit && (remain == RAM_ADDR_BITS'(1))) begin
            state_d = ST_DONE;
          end
        end
        default: state_d = state_q;
      endcase
    end
  end

  always_comb begin
    wr_ena = 1'b0;
    if (!cmd_any) begin
      case (state_q)
        ST_ARMED:     wr_ena = store_hit || trig_hit;
        ST_POST_TRIG: wr_ena = store_hit;
        default:      wr_ena = 1'b0;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr       <= '0;
      trigger_addr <= '0;
      wrapped      <= 1'b0;
      remain       <= '0;
      prev_signals <= '0;
    end else begin
      prev_signals <= signals;
      if (cmd_clear) begin
        wr_ptr       <= '0;
        trigger_addr <= '0;
        wrapped      <= 1'b0;
        remain       <= '0;
      end else if (cmd_start) begin
        wr_ptr       <= '0;
        trigger_addr <= '0;
        wrapped      <= 1'b0;
      end else if (wr_ena) begin
        wr_ptr <= wr_ptr + RAM_ADDR_BITS'(1);
        if (wr_ptr == '1) begin
          wrapped <= 1'b1;
        end
        // The trigger sample latches the post-trigger budget; later edits are ignored.
        if ((state_q == ST_ARMED) && trig_hit) begin
          trigger_addr <= wr_ptr;
          remain       <= post_trig_cnt;
        end else if (state_q == ST_POST_TRIG) begin
          remain <= remain - RAM_ADDR_BITS'(1);
        end
      end
    end
  end

  assign bus.ram_wr_ena  = wr_ena;
  assign bus.ram_wr_addr = wr_ptr;
  assign bus.ram_wr_data = signals;
  assign state           = state_q;
  assign busy            = capturing;

endmodule
